sprite_display_gen: RTL and testbench

- Generalised sprite renderer for the 640x480 RGB565 VGA path; successor to the fixed-position single-image display blocks.
- Adds a runtime-movable position, power-of-two scaling, multi-frame animation, transparent colour key, blinking, and an external sprite ROM of configurable read latency.
- Output is a registered RGB565 pixel plus a hit flag, so a downstream mixer can layer several instances.

---
 rtl/sprite_display_gen_if.sv | 35 +++
 rtl/sprite_display_gen.sv | 183 ++++++++++++++++++
 tb/tb_sprite_display_gen.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_display_gen_if.sv
// Pixel-stream, sprite ROM and render-output bundle for one sprite_display_gen instance.
// Latency: none, signal grouping only.
// Backpressure: none, the pixel stream is free-running.
interface sprite_display_gen_if #(
  parameter int ADDR_W = 13,
  parameter int FIDX_W = 2
);
  // raster position and frame controls
  logic [9:0]        vga_x;
  logic [9:0]        vga_y;
  logic              video_on;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              anim_en;
  logic              blink_en;
  // external sprite ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  // rendered pixel
  logic [15:0]       rgb;
  logic              sprite_hit;
  logic [FIDX_W-1:0] frame_idx;

  // timing/ROM side: drives the raster and ROM data, consumes the pixel
  modport master (
    output vga_x, vga_y, video_on, pos_x, pos_y, anim_en, blink_en, rom_data,
    input  rom_addr, rgb, sprite_hit, frame_idx
  );

  // renderer side
  modport slave (
    input  vga_x, vga_y, video_on, pos_x, pos_y, anim_en, blink_en, rom_data,
    output rom_addr, rgb, sprite_hit, frame_idx
  );
endinterface

// File: rtl/sprite_display_gen.sv
// Sprite renderer: movable, 2^n-scaled, animated, blinking, colour-keyed sprite from an external ROM.
// Latency: ROM_LAT+1 clocks from vga_x/vga_y to rgb/sprite_hit; rom_addr is combinational.
// Backpressure: none; consumes one pixel per clock unconditionally.
module sprite_display_gen #(
  parameter int          IMG_W        = 64,
  parameter int          IMG_H        = 20,
  parameter int          SCALE_LOG2   = 1,
  parameter int          NUM_FRAMES   = 4,
  parameter int          FRAME_HOLD   = 8,
  parameter int          BLINK_PERIOD = 30,
  parameter int          ROM_LAT      = 1,
  parameter int          ADDR_W       = 13,
  parameter logic [15:0] KEY_COLOR    = 16'hF81F
) (
  input  logic vga_clk,
  input  logic sys_rst_n,
  sprite_display_gen_if.slave bus
);

  localparam int DISP_W   = IMG_W << SCALE_LOG2;
  localparam int DISP_H   = IMG_H << SCALE_LOG2;
  localparam int FRAME_SZ = IMG_W * IMG_H;
  localparam int FIDX_W   = (NUM_FRAMES > 1)   ? $clog2(NUM_FRAMES)   : 1;
  localparam int HOLD_W   = (FRAME_HOLD > 1)   ? $clog2(FRAME_HOLD)   : 1;
  localparam int BLINK_W  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_ph_t;

  // latched sprite position and animation/blink state
  logic [9:0]         r_pos_x;
  logic [9:0]         r_pos_y;
  logic [HOLD_W-1:0]  r_hold;
  logic [FIDX_W-1:0]  r_frame_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [BLINK_W-1:0] w_blink_cnt_nxt;
  blink_ph_t          r_phase;
  blink_ph_t          w_phase_nxt;

  // per-stage {video_on, in_area, visible}, aligned with ROM read latency
  logic [ROM_LAT-1:0][2:0] r_dly;

  logic [15:0] r_rgb;
  logic        r_hit;

  logic        w_frame_tick;
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic [10:0] w_px11;
  logic [10:0] w_py11;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_area;
  logic [9:0]  w_rel_x;
  logic [9:0]  w_rel_y;
  logic [9:0]  w_img_x;
  logic [9:0]  w_img_y;
  logic [ADDR_W-1:0] w_addr;
  logic        w_von_d;
  logic        w_area_d;
  logic        w_vis_d;
  logic        w_hit;

  // top-left pixel of the raster marks the start of a video frame
  assign w_frame_tick = (bus.vga_x == 10'd0) && (bus.vga_y == 10'd0);

  // Window test in 11 bits so a sprite hanging off the right/bottom edge is clipped
  // there instead of reappearing at the left/top.
  assign w_x11   = {1'b0, bus.vga_x};
  assign w_y11   = {1'b0, bus.vga_y};
  assign w_px11  = {1'b0, r_pos_x};
  assign w_py11  = {1'b0, r_pos_y};
  assign w_x_end = w_px11 + 11'(DISP_W);
  assign w_y_end = w_py11 + 11'(DISP_H);
  assign w_in_area = (w_x11 >= w_px11) && (w_x11 < w_x_end) &&
                     (w_y11 >= w_py11) && (w_y11 < w_y_end);

  // Source texel: offset inside the sprite, downscaled by a plain shift.
  assign w_rel_x = bus.vga_x - r_pos_x;
  assign w_rel_y = bus.vga_y - r_pos_y;
  assign w_img_x = w_rel_x >> SCALE_LOG2;
  assign w_img_y = w_rel_y >> SCALE_LOG2;

  // Frames are stored back to back, so the frame index selects a FRAME_SZ block.
  assign w_addr = ADDR_W'(r_frame_idx) * ADDR_W'(FRAME_SZ) +
                  ADDR_W'(w_img_y) * ADDR_W'(IMG_W) +
                  ADDR_W'(w_img_x);

  assign bus.rom_addr = w_in_area ? w_addr : '0;

  // latch position at the frame tick; the tick pixel itself still sees the old one
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else if (w_frame_tick) begin
      r_pos_x <= bus.pos_x;
      r_pos_y <= bus.pos_y;
    end
  end

  // animation: hold each frame FRAME_HOLD ticks, freeze (not clear) when disabled
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold      <= '0;
      r_frame_idx <= '0;
    end else if (w_frame_tick && bus.anim_en) begin
      if (r_hold == HOLD_W'(FRAME_HOLD - 1)) begin
        r_hold <= '0;
        if (r_frame_idx == FIDX_W'(NUM_FRAMES - 1)) begin
          r_frame_idx <= '0;
        end else begin
          r_frame_idx <= r_frame_idx + 1'b1;
        end
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  // blink phase and tick counter state register
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_phase     <= PH_VISIBLE;
      r_blink_cnt <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  // blink next state: toggle every BLINK_PERIOD ticks; disabling forces visible at once
  always_comb begin
    w_phase_nxt     = r_phase;
    w_blink_cnt_nxt = r_blink_cnt;
    if (!bus.blink_en) begin
      w_phase_nxt     = PH_VISIBLE;
      w_blink_cnt_nxt = '0;
    end else if (w_frame_tick) begin
      if (r_blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
      end
    end
  end

  // delay the pixel qualifiers so they line up with rom_data
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= {bus.video_on, w_in_area, (r_phase == PH_VISIBLE)};
      for (int i = 1; i < ROM_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_von_d  = r_dly[ROM_LAT-1][2];
  assign w_area_d = r_dly[ROM_LAT-1][1];
  assign w_vis_d  = r_dly[ROM_LAT-1][0];
  assign w_hit    = w_von_d && w_area_d && w_vis_d && (bus.rom_data != KEY_COLOR);

  // registered output pixel: black whenever this sprite does not own the pixel
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rgb <= '0;
      r_hit <= 1'b0;
    end else begin
      r_rgb <= w_hit ? bus.rom_data : 16'h0000;
      r_hit <= w_hit;
    end
  end

  assign bus.rgb        = r_rgb;
  assign bus.sprite_hit = r_hit;
  assign bus.frame_idx  = r_frame_idx;

endmodule

// File: tb/tb_sprite_display_gen.sv
// Bench for sprite_display_gen: ROM_LAT=1 and ROM_LAT=3 instances fed the same raster.
// Latency: expectations are checked ROM_LAT+1 clocks after each pixel.
// Backpressure: none; raster is driven one pixel per clock.
`timescale 1ns/1ps
module tb_sprite_display_gen;

  localparam int IMG_W        = 64;
  localparam int IMG_H        = 20;
  localparam int SCALE_LOG2   = 1;
  localparam int NUM_FRAMES   = 4;
  localparam int FRAME_HOLD   = 8;
  localparam int BLINK_PERIOD = 30;
  localparam int ADDR_W       = 13;
  localparam logic [15:0] KEY = 16'hF81F;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int DW   = IMG_W << SCALE_LOG2;
  localparam int DH   = IMG_H << SCALE_LOG2;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  sprite_display_gen_if #(.ADDR_W(ADDR_W), .FIDX_W(2)) bus0 ();
  sprite_display_gen_if #(.ADDR_W(ADDR_W), .FIDX_W(2)) bus1 ();

  sprite_display_gen #(.ROM_LAT(LAT0)) u0 (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(bus0));
  sprite_display_gen #(.ROM_LAT(LAT1)) u1 (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(bus1));

  assign bus1.vga_x    = bus0.vga_x;
  assign bus1.vga_y    = bus0.vga_y;
  assign bus1.video_on = bus0.video_on;
  assign bus1.pos_x    = bus0.pos_x;
  assign bus1.pos_y    = bus0.pos_y;
  assign bus1.anim_en  = bus0.anim_en;
  assign bus1.blink_en = bus0.blink_en;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b1;

  // ROM content: data equals address, except a colour-key texel at address 5
  function automatic logic [15:0] rom_val(input int a);
    return (a == 5) ? KEY : 16'(a);
  endfunction

  logic [15:0] rom0_q [LAT0];
  logic [15:0] rom1_q [LAT1];
  always @(posedge vga_clk) begin
    rom0_q[0] <= rom_val(int'(bus0.rom_addr));
    for (int i = 1; i < LAT0; i++) rom0_q[i] <= rom0_q[i-1];
    rom1_q[0] <= rom_val(int'(bus1.rom_addr));
    for (int i = 1; i < LAT1; i++) rom1_q[i] <= rom1_q[i-1];
  end
  assign bus0.rom_data = rom0_q[LAT0-1];
  assign bus1.rom_data = rom1_q[LAT1-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in effect, count of animated ticks, count of ticks since blink enabled.
  int m_px = 0, m_py = 0, m_anim_ticks = 0, m_blink_ticks = 0;
  logic [15:0] h_rgb [4] = '{default: '0};
  logic        h_hit [4] = '{default: 1'b0};

  typedef struct packed {
    logic [15:0] addr;
    logic        hit;
    logic [15:0] rgb;
  } pix_t;

  function automatic int m_frame();
    return (m_anim_ticks / FRAME_HOLD) % NUM_FRAMES;
  endfunction

  function automatic bit m_vis();
    return ((m_blink_ticks / BLINK_PERIOD) % 2) == 0;
  endfunction

  function automatic pix_t exp_pixel(input int x, input int y, input bit von);
    pix_t p;
    int a;
    bit in_a;
    logic [15:0] d;
    in_a = (x >= m_px) && (x < m_px + DW) && (y >= m_py) && (y < m_py + DH);
    a = in_a ? m_frame() * IMG_W * IMG_H + ((y - m_py) >> SCALE_LOG2) * IMG_W + ((x - m_px) >> SCALE_LOG2) : 0;
    d = rom_val(a);
    p.addr = 16'(a);
    p.hit  = von && in_a && m_vis() && (d != KEY);
    p.rgb  = p.hit ? d : 16'h0000;
    return p;
  endfunction

  // advance the model one pixel; history[k] = expectation for the pixel k clocks ago
  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_px <= 0; m_py <= 0; m_anim_ticks <= 0; m_blink_ticks <= 0;
      for (int i = 0; i < 4; i++) begin h_rgb[i] <= '0; h_hit[i] <= 1'b0; end
    end else begin
      pix_t p;
      bit tk;
      p  = exp_pixel(int'(bus0.vga_x), int'(bus0.vga_y), bus0.video_on);
      tk = (bus0.vga_x == 10'd0) && (bus0.vga_y == 10'd0);
      for (int i = 3; i > 0; i--) begin h_rgb[i] <= h_rgb[i-1]; h_hit[i] <= h_hit[i-1]; end
      h_rgb[0] <= p.rgb;
      h_hit[0] <= p.hit;
      if (tk) begin
        m_px <= int'(bus0.pos_x);
        m_py <= int'(bus0.pos_y);
        if (bus0.anim_en) m_anim_ticks <= m_anim_ticks + 1;
      end
      if (!bus0.blink_en) m_blink_ticks <= 0;
      else if (tk)        m_blink_ticks <= m_blink_ticks + 1;
    end
  end

  // continuous scoreboard, sampled on the falling edge
  always @(negedge vga_clk) begin
    if (sb_en) begin
      pix_t p;
      p = exp_pixel(int'(bus0.vga_x), int'(bus0.vga_y), bus0.video_on);
      chk("sb_addr0", 32'(bus0.rom_addr), 32'(p.addr));
      chk("sb_addr1", 32'(bus1.rom_addr), 32'(p.addr));
      chk("sb_rgb0",  32'(bus0.rgb), 32'(h_rgb[LAT0]));
      chk("sb_hit0",  32'(bus0.sprite_hit), 32'(h_hit[LAT0]));
      chk("sb_rgb1",  32'(bus1.rgb), 32'(h_rgb[LAT1]));
      chk("sb_hit1",  32'(bus1.sprite_hit), 32'(h_hit[LAT1]));
      chk("sb_fidx0", 32'(bus0.frame_idx), 32'(m_frame()));
      chk("sb_fidx1", 32'(bus1.frame_idx), 32'(m_frame()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge vga_clk); #1; end
  endtask

  task automatic px(input int x, input int y, input bit von = 1'b1);
    bus0.vga_x    = 10'(x);
    bus0.vga_y    = 10'(y);
    bus0.video_on = von;
  endtask

  task automatic tick();
    px(0, 0);
    step(1);
  endtask

  typedef struct {
    int x;
    int y;
    bit von;
    int addr;
    bit hit;
    int rgb;
  } vec_t;

  vec_t tv [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1;
    // vectors at pos=(100,50), frame 0, visible
    tv[0]  = '{100, 50, 1'b1,    0, 1'b1,    0};
    tv[1]  = '{103, 51, 1'b1,    1, 1'b1,    1};
    tv[2]  = '{227, 89, 1'b1, 1279, 1'b1, 1279};
    tv[3]  = '{228, 89, 1'b1,    0, 1'b0,    0};
    tv[4]  = '{110, 50, 1'b1,    5, 1'b0,    0};
    tv[5]  = '{111, 50, 1'b1,    5, 1'b0,    0};
    tv[6]  = '{112, 50, 1'b1,    6, 1'b1,    6};
    tv[7]  = '{109, 50, 1'b1,    4, 1'b1,    4};
    tv[8]  = '{ 99, 50, 1'b1,    0, 1'b0,    0};
    tv[9]  = '{100, 49, 1'b1,    0, 1'b0,    0};
    tv[10] = '{100, 89, 1'b1, 1216, 1'b1, 1216};
    tv[11] = '{100, 90, 1'b1,    0, 1'b0,    0};
    tv[12] = '{103, 51, 1'b0,    1, 1'b0,    0};

    bus0.pos_x = 10'd100; bus0.pos_y = 10'd50;
    bus0.anim_en = 1'b0; bus0.blink_en = 1'b0;
    px(5, 5);
    #22;
    chk("rst_rgb",  32'(bus0.rgb), 0);
    chk("rst_hit",  32'(bus0.sprite_hit), 0);
    chk("rst_fidx", 32'(bus0.frame_idx), 0);
    sys_rst_n = 1'b1;
    step(1);

    // latch position, then apply the vector table
    tick();
    foreach (tv[i]) begin
      px(tv[i].x, tv[i].y, tv[i].von);
      #1;
      chk($sformatf("tv%0d_addr", i), 32'(bus0.rom_addr), 32'(tv[i].addr));
      step(4);
      chk($sformatf("tv%0d_hit0", i), 32'(bus0.sprite_hit), 32'(tv[i].hit));
      chk($sformatf("tv%0d_rgb0", i), 32'(bus0.rgb), 32'(tv[i].rgb));
      chk($sformatf("tv%0d_hit1", i), 32'(bus1.sprite_hit), 32'(tv[i].hit));
      chk($sformatf("tv%0d_rgb1", i), 32'(bus1.rgb), 32'(tv[i].rgb));
    end

    // position change mid-frame waits for the next (0,0)
    bus0.pos_x = 10'd300; bus0.pos_y = 10'd300;
    px(100, 50); step(4);
    chk("midpos_old_hit", 32'(bus0.sprite_hit), 1);
    tick();
    px(100, 50); step(4);
    chk("midpos_gone_hit", 32'(bus0.sprite_hit), 0);
    px(300, 300); step(4);
    chk("midpos_new_hit", 32'(bus0.sprite_hit), 1);

    // bottom-right overhang clips, no wrap to left/top
    bus0.pos_x = 10'd600; bus0.pos_y = 10'd460;
    tick();
    px(639, 479); step(4);
    chk("clip_corner_hit", 32'(bus0.sprite_hit), 1);
    chk("clip_corner_rgb", 32'(bus0.rgb), 595);
    px(600, 460); step(4);
    chk("clip_origin_hit", 32'(bus0.sprite_hit), 1);
    for (int x = 1; x < 88; x++) begin px(x, 470); step(1); end
    for (int y = 1; y < 20; y++) begin px(620, y); step(1); end
    px(50, 10); step(4);
    chk("clip_nowrap_hit", 32'(bus0.sprite_hit), 0);

    // animation: frame advances every FRAME_HOLD ticks
    bus0.pos_x = 10'd100; bus0.pos_y = 10'd50;
    tick();
    bus0.anim_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("anim_fidx_t%0d", k), 32'(bus0.frame_idx), 32'((k / 8) % 4));
      px(100, 50); step(1);
    end
    bus0.anim_en = 1'b0;
    px(100, 50); #1;
    chk("anim_f1_addr", 32'(bus0.rom_addr), 1280);
    step(1);

    // blink: hidden for ticks 30..59 and 90..119
    bus0.blink_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      px(100, 50); step(4);
      chk($sformatf("blink_hit_t%0d", k), 32'(bus0.sprite_hit), 32'(((k / 30) % 2) == 0));
    end
    bus0.blink_en = 1'b0;
    step(2);
    chk("blink_drop_pipe_hit", 32'(bus0.sprite_hit), 0);
    step(1);
    chk("blink_drop_vis_hit", 32'(bus0.sprite_hit), 1);

    // asynchronous reset in the middle of a line
    px(120, 60); step(4);
    chk("arst_pre_hit", 32'(bus0.sprite_hit), 1);
    chk("arst_pre_rgb", 32'(bus0.rgb), 1610);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_rgb0", 32'(bus0.rgb), 0);
    chk("arst_hit0", 32'(bus0.sprite_hit), 0);
    chk("arst_fidx", 32'(bus0.frame_idx), 0);
    chk("arst_rgb1", 32'(bus1.rgb), 0);
    step(2);
    sys_rst_n = 1'b1;
    px(10, 10); step(6);
    chk("arst_refill_rgb", 32'(bus0.rgb), 325);

    // latency measured in clocks for both ROM latencies
    bus0.pos_x = 10'd100; bus0.pos_y = 10'd50;
    tick();
    px(700, 400); step(5);
    px(102, 50);
    l0 = 0; l1 = 0;
    for (int n = 1; n <= 10; n++) begin
      step(1);
      if (bus0.sprite_hit && l0 == 0) l0 = n;
      if (bus1.sprite_hit && l1 == 0) l1 = n;
    end
    chk("lat_rom1", l0, 2);
    chk("lat_rom3", l1, 4);

    // randomized raster, positions and enables against the model
    for (int c = 0; c < 3000; c++) begin
      int x, y, r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        px(0, 0);
      end else if (r < 60) begin
        x = int'(bus0.pos_x) + int'($urandom_range(0, DW + 8)) - 4;
        y = int'(bus0.pos_y) + int'($urandom_range(0, DH + 8)) - 4;
        if (x < 0) x = 1;
        if (y < 0) y = 1;
        if (x > 1023) x = 1023;
        if (y > 1023) y = 1023;
        px(x, y, $urandom_range(0, 9) != 0);
      end else begin
        px(int'($urandom_range(1, 639)), int'($urandom_range(0, 479)), $urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 99) < 2) begin
        bus0.pos_x = 10'($urandom_range(0, 639));
        bus0.pos_y = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 99) < 1) bus0.anim_en  = ~bus0.anim_en;
      if ($urandom_range(0, 99) < 1) bus0.blink_en = ~bus0.blink_en;
      step(1);
    end

    sb_en = 1'b0;
    step(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
